// File: rtl/instr_encoder.sv
// rv32_pkg: instruction packet layout shared by decode/encode stages.
// instr_encoder: RV32IM packet -> machine word, 1-cycle registered, output holds under backpressure.
package rv32_pkg;
   typedef enum logic [5:0] {
      ALU_OP_NOP, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
      ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
      ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
      ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
      ALU_OP_ADDI, ALU_OP_SLTI, ALU_OP_SLTIU, ALU_OP_XORI, ALU_OP_ORI, ALU_OP_ANDI,
      ALU_OP_SLLI, ALU_OP_SRLI, ALU_OP_SRAI,
      ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_LBU, ALU_OP_LHU,
      ALU_OP_SB, ALU_OP_SH, ALU_OP_SW,
      ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT, ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU,
      ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_JAL, ALU_OP_JALR
   } alu_op_e;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm32;
   } rv32_instr_packet_t;
endpackage

module instr_encoder
   import rv32_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  rv32_instr_packet_t  in_packet,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_illegal,
   input  logic                cfg_restart,
   output logic [15:0]         word_count,
   output logic [7:0]          err_count
);

   typedef enum logic [3:0] {
      FMT_BAD, FMT_NOP, FMT_R, FMT_I, FMT_SH, FMT_LD, FMT_JALR,
      FMT_S, FMT_B, FMT_LUI, FMT_AUIPC, FMT_J
   } fmt_e;

   fmt_e              w_fmt;
   logic [2:0]        w_f3;
   logic [6:0]        w_f7;
   logic [31:0]       w_imm;
   logic [4:0]        w_rd, w_rs1, w_rs2;
   logic              w_fit12, w_fit13, w_fit21;
   logic              w_legal;
   logic [31:0]       w_raw;
   logic              w_acc, w_out_hs;

   logic              r_out_vld;
   logic [31:0]       r_out_instr;
   logic              r_out_ill;
   logic [ADDR_W-1:0] r_out_addr;
   logic [15:0]       r_word_cnt;
   logic [7:0]        r_err_cnt;

   assign w_imm = in_packet.imm32;
   assign w_rd  = in_packet.rd;
   assign w_rs1 = in_packet.rs1;
   assign w_rs2 = in_packet.rs2;

   // Immediate fits an N-bit signed field when all bits above it copy its sign bit.
   assign w_fit12 = (w_imm[31:12] == {20{w_imm[11]}});
   assign w_fit13 = (w_imm[31:13] == {19{w_imm[12]}});
   assign w_fit21 = (w_imm[31:21] == {11{w_imm[20]}});

   always_comb begin
      w_fmt = FMT_BAD;
      w_f3  = 3'd0;
      w_f7  = 7'b0000000;
      case (in_packet.alu_op)
         ALU_OP_NOP:    w_fmt = FMT_NOP;
         ALU_OP_ADD:    begin w_fmt = FMT_R; w_f3 = 3'd0; end
         ALU_OP_SUB:    begin w_fmt = FMT_R; w_f3 = 3'd0; w_f7 = 7'b0100000; end
         ALU_OP_SLL:    begin w_fmt = FMT_R; w_f3 = 3'd1; end
         ALU_OP_SLT:    begin w_fmt = FMT_R; w_f3 = 3'd2; end
         ALU_OP_SLTU:   begin w_fmt = FMT_R; w_f3 = 3'd3; end
         ALU_OP_XOR:    begin w_fmt = FMT_R; w_f3 = 3'd4; end
         ALU_OP_SRL:    begin w_fmt = FMT_R; w_f3 = 3'd5; end
         ALU_OP_SRA:    begin w_fmt = FMT_R; w_f3 = 3'd5; w_f7 = 7'b0100000; end
         ALU_OP_OR:     begin w_fmt = FMT_R; w_f3 = 3'd6; end
         ALU_OP_AND:    begin w_fmt = FMT_R; w_f3 = 3'd7; end
         ALU_OP_MUL:    begin w_fmt = FMT_R; w_f3 = 3'd0; w_f7 = 7'b0000001; end
         ALU_OP_MULH:   begin w_fmt = FMT_R; w_f3 = 3'd1; w_f7 = 7'b0000001; end
         ALU_OP_MULHSU: begin w_fmt = FMT_R; w_f3 = 3'd2; w_f7 = 7'b0000001; end
         ALU_OP_MULHU:  begin w_fmt = FMT_R; w_f3 = 3'd3; w_f7 = 7'b0000001; end
         ALU_OP_DIV:    begin w_fmt = FMT_R; w_f3 = 3'd4; w_f7 = 7'b0000001; end
         ALU_OP_DIVU:   begin w_fmt = FMT_R; w_f3 = 3'd5; w_f7 = 7'b0000001; end
         ALU_OP_REM:    begin w_fmt = FMT_R; w_f3 = 3'd6; w_f7 = 7'b0000001; end
         ALU_OP_REMU:   begin w_fmt = FMT_R; w_f3 = 3'd7; w_f7 = 7'b0000001; end
         ALU_OP_ADDI:   begin w_fmt = FMT_I; w_f3 = 3'd0; end
         ALU_OP_SLTI:   begin w_fmt = FMT_I; w_f3 = 3'd2; end
         ALU_OP_SLTIU:  begin w_fmt = FMT_I; w_f3 = 3'd3; end
         ALU_OP_XORI:   begin w_fmt = FMT_I; w_f3 = 3'd4; end
         ALU_OP_ORI:    begin w_fmt = FMT_I; w_f3 = 3'd6; end
         ALU_OP_ANDI:   begin w_fmt = FMT_I; w_f3 = 3'd7; end
         ALU_OP_SLLI:   begin w_fmt = FMT_SH; w_f3 = 3'd1; end
         ALU_OP_SRLI:   begin w_fmt = FMT_SH; w_f3 = 3'd5; end
         ALU_OP_SRAI:   begin w_fmt = FMT_SH; w_f3 = 3'd5; w_f7 = 7'b0100000; end
         ALU_OP_LB:     begin w_fmt = FMT_LD; w_f3 = 3'd0; end
         ALU_OP_LH:     begin w_fmt = FMT_LD; w_f3 = 3'd1; end
         ALU_OP_LW:     begin w_fmt = FMT_LD; w_f3 = 3'd2; end
         ALU_OP_LBU:    begin w_fmt = FMT_LD; w_f3 = 3'd4; end
         ALU_OP_LHU:    begin w_fmt = FMT_LD; w_f3 = 3'd5; end
         ALU_OP_SB:     begin w_fmt = FMT_S; w_f3 = 3'd0; end
         ALU_OP_SH:     begin w_fmt = FMT_S; w_f3 = 3'd1; end
         ALU_OP_SW:     begin w_fmt = FMT_S; w_f3 = 3'd2; end
         ALU_OP_BEQ:    begin w_fmt = FMT_B; w_f3 = 3'd0; end
         ALU_OP_BNE:    begin w_fmt = FMT_B; w_f3 = 3'd1; end
         ALU_OP_BLT:    begin w_fmt = FMT_B; w_f3 = 3'd4; end
         ALU_OP_BGE:    begin w_fmt = FMT_B; w_f3 = 3'd5; end
         ALU_OP_BLTU:   begin w_fmt = FMT_B; w_f3 = 3'd6; end
         ALU_OP_BGEU:   begin w_fmt = FMT_B; w_f3 = 3'd7; end
         ALU_OP_LUI:    w_fmt = FMT_LUI;
         ALU_OP_AUIPC:  w_fmt = FMT_AUIPC;
         ALU_OP_JAL:    w_fmt = FMT_J;
         ALU_OP_JALR:   begin w_fmt = FMT_JALR; w_f3 = 3'd0; end
         default:       w_fmt = FMT_BAD;
      endcase
   end

   always_comb begin
      w_legal = 1'b0;
      w_raw   = 32'h0000_0000;
      case (w_fmt)
         FMT_NOP:   begin w_legal = 1'b1; w_raw = 32'h0000_0013; end
         FMT_R:     begin w_legal = 1'b1; w_raw = {w_f7, w_rs2, w_rs1, w_f3, w_rd, 7'b0110011}; end
         FMT_I:     begin w_legal = w_fit12; w_raw = {w_imm[11:0], w_rs1, w_f3, w_rd, 7'b0010011}; end
         FMT_LD:    begin w_legal = w_fit12; w_raw = {w_imm[11:0], w_rs1, w_f3, w_rd, 7'b0000011}; end
         FMT_JALR:  begin w_legal = w_fit12; w_raw = {w_imm[11:0], w_rs1, w_f3, w_rd, 7'b1100111}; end
         FMT_SH:    begin
            w_legal = (w_imm[31:5] == 27'd0);
            w_raw   = {w_f7, w_imm[4:0], w_rs1, w_f3, w_rd, 7'b0010011};
         end
         FMT_S:     begin
            w_legal = w_fit12;
            w_raw   = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], 7'b0100011};
         end
         FMT_B:     begin
            w_legal = w_fit13 && !w_imm[0];
            w_raw   = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3, w_imm[4:1], w_imm[11], 7'b1100011};
         end
         FMT_LUI:   begin w_legal = (w_imm[11:0] == 12'd0); w_raw = {w_imm[31:12], w_rd, 7'b0110111}; end
         FMT_AUIPC: begin w_legal = (w_imm[11:0] == 12'd0); w_raw = {w_imm[31:12], w_rd, 7'b0010111}; end
         FMT_J:     begin
            w_legal = w_fit21 && !w_imm[0];
            w_raw   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, 7'b1101111};
         end
         default:   begin w_legal = 1'b0; w_raw = 32'h0000_0000; end
      endcase
   end

   assign in_ready = !r_out_vld || out_ready;
   assign w_acc    = in_valid && in_ready;
   assign w_out_hs = r_out_vld && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_vld   <= 1'b0;
         r_out_instr <= 32'h0000_0000;
         r_out_ill   <= 1'b0;
      end else if (w_acc) begin
         r_out_vld   <= 1'b1;
         r_out_instr <= w_legal ? w_raw : 32'h0000_0000;
         r_out_ill   <= !w_legal;
      end else if (w_out_hs) begin
         r_out_vld   <= 1'b0;
      end
   end

   // Restart wins over the delivery increment; a held word simply re-labels to BASE_ADDR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_addr <= BASE_ADDR;
         r_word_cnt <= 16'd0;
         r_err_cnt  <= 8'd0;
      end else if (cfg_restart) begin
         r_out_addr <= BASE_ADDR;
         r_word_cnt <= 16'd0;
         r_err_cnt  <= 8'd0;
      end else if (w_out_hs) begin
         r_out_addr <= r_out_addr + ADDR_W'(4);
         if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
         if (r_out_ill && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign out_valid   = r_out_vld;
   assign out_instr   = r_out_instr;
   assign out_illegal = r_out_ill;
   assign out_addr    = r_out_addr;
   assign word_count  = r_word_cnt;
   assign err_count   = r_err_cnt;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode stage: converts an rv32_instr_packet_t (rs1/rs2/rd/imm32/alu_op) back into a 32-bit RV32IM machine word.
- Streams encoded words with sequential word addresses for writing into instruction memory (self-test program loader, trace replay).
- Valid/ready handshake on both sides; one registered output stage; range-checks each field and flags illegal encodings.

Parameters:
- ADDR_W, 32, width of out_addr (byte address).
- BASE_ADDR, 32'h0000_0000, address used after reset and on cfg_restart.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input packet valid.
- in_ready  output  1  block can accept a packet this cycle.
- in_packet  input  $bits(rv32_instr_packet_t)  packet to encode (rv32_pkg).
- out_valid  output  1  out_instr/out_addr/out_illegal valid.
- out_ready  input  1  consumer accepts the output word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address of out_instr.
- out_illegal  output  1  packet could not be legally encoded.
- cfg_restart  input  1  single-cycle pulse: reload address counter to BASE_ADDR.
- word_count  output  16  accepted output words since reset/restart, saturating.
- err_count  output  8  illegal words emitted since reset/restart, saturating at 8'hFF.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_illegal=0, out_addr=BASE_ADDR, word_count=0, err_count=0, in_ready=1.
- in_ready = !out_valid || out_ready (combinational). Input accepted on in_valid && in_ready. The registered result appears with out_valid=1 on the next edge (latency 1). Back-to-back throughput is 1 word/cycle.
- Holding output: while out_valid && !out_ready, out_instr, out_addr and out_illegal stay stable and no new packet is accepted.
- Output handshake: on out_valid && out_ready, out_addr increments by 4 (wraps modulo 2^ADDR_W) and word_count increments (saturates at 16'hFFFF). If out_illegal is also 1, err_count increments.
- Simultaneous output handshake and new acceptance: the new word is loaded with out_valid held at 1. Its out_addr is the incremented address.
- Encoding uses standard RV32IM formats.
  - rd at [11:7], rs1 at [19:15], rs2 at [24:20]. Fields unused by a format are ignored.
  - R-type covers ADD..SRA and MUL..REMU. funct7 is 7'b0000000 except SUB/SRA (7'b0100000) and the M ops (7'b0000001).
  - I-type covers ADDI/SLTI/SLTIU/XORI/ORI/ANDI, loads and JALR, using imm32[11:0].
  - SLLI/SRLI/SRAI place imm32[4:0] as shamt in [24:20] and funct7 in [31:25] (SRAI 7'b0100000).
  - S, B, U and J types use standard immediate scrambling from imm32.
- Illegal conditions set out_illegal=1 and out_instr=32'h0000_0000:
  - I/S-type: imm32 is not the sign-extension of imm32[11:0].
  - Shifts: imm32[31:5] != 0.
  - B-type: imm32 outside [-4096, 4094], or imm32[0] = 1.
  - J-type: imm32 outside ±1 MiB, or imm32[0] = 1.
  - U-type: imm32[11:0] != 0.
  - alu_op not a defined enum value.
- ALU_OP_NOP encodes as 32'h0000_0013 (ADDI x0,x0,0), legal.
- cfg_restart:
  - Sets out_addr=BASE_ADDR, word_count=0, err_count=0 next edge and takes priority over the handshake increment.
  - Does not drop a pending out_valid word; that word takes BASE_ADDR.
- Reset mid-operation: a pending output is discarded and no partial state is retained.
- No X propagation: out_instr holds its last value when out_valid=0.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, then MUL same regs, out_ready=1 → out_instr 32'h002081B3 then 32'h022081B3. out_addr 0x0 then 0x4, one cycle after each acceptance.
- ADDI rd=1 rs1=0 imm32=32'hFFFF_FFFF → 32'hFFF00093, out_illegal=0. Same with imm32=32'h0000_0800 → out_instr 0, out_illegal=1, err_count=1.
- BEQ rs1=1 rs2=2 imm=8 → 32'h00208463. SW rs2=5 rs1=2 imm=12 → 32'h00512623. LUI rd=5 imm32=32'h1234_5000 → 32'h123452B7. BEQ imm=7 → illegal.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → words delivered in order at consecutive addresses, no loss or duplication.
- cfg_restart pulse in the same cycle as an output handshake at out_addr=0x10 → out_addr=BASE_ADDR and word_count=0 next cycle.
- Assert rst while out_valid=1 and out_ready=0 → out_valid=0 and counters 0 immediately. The first packet after release gets out_addr=BASE_ADDR.
